// File: rtl/ldm_stm_sequencer_if.sv
// ldm_stm_sequencer_if: decode request, data-bus and register-file signals of the LDM/STM sequencer.
// The sequencer uses the slave modport; the decode/bus/regfile side uses master.
interface ldm_stm_sequencer_if;
    logic        START;
    logic        IS_LOAD;
    logic        DECR;
    logic        WBACK_EN;
    logic [15:0] REGLIST;
    logic [3:0]  BASE_REG;
    logic [31:0] BASE_ADDR;
    logic        BUSY;
    logic        DONE;
    logic        MEM_REQ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        MEM_READY;
    logic [31:0] MEM_RDATA;
    logic [3:0]  REG_RA;
    logic [31:0] REG_RDATA;
    logic        REG_WEN1;
    logic [3:0]  REG_WA1;
    logic [31:0] REG_DI1;
    logic        REG_WEN2;
    logic [3:0]  REG_WA2;
    logic [31:0] REG_DI2;
    logic        PC_WEN;
    logic [31:0] PC_DI;
    logic        FAULT;

    modport slave (
        input  START, IS_LOAD, DECR, WBACK_EN, REGLIST, BASE_REG, BASE_ADDR,
               MEM_READY, MEM_RDATA, REG_RDATA,
        output BUSY, DONE, MEM_REQ, MEM_WRITE, MEM_ADDR, MEM_WDATA, REG_RA,
               REG_WEN1, REG_WA1, REG_DI1, REG_WEN2, REG_WA2, REG_DI2,
               PC_WEN, PC_DI, FAULT
    );

    modport master (
        output START, IS_LOAD, DECR, WBACK_EN, REGLIST, BASE_REG, BASE_ADDR,
               MEM_READY, MEM_RDATA, REG_RDATA,
        input  BUSY, DONE, MEM_REQ, MEM_WRITE, MEM_ADDR, MEM_WDATA, REG_RA,
               REG_WEN1, REG_WA1, REG_DI1, REG_WEN2, REG_WA2, REG_DI2,
               PC_WEN, PC_DI, FAULT
    );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: LDM/STM/PUSH/POP sequencer, one register per memory beat.
// Define LDM_ALIGN_CHECK_EN to fault a misaligned start address instead of issuing beats.
module ldm_stm_sequencer #(
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    ldm_stm_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_list;
    logic        r_is_load;
    logic        r_wback;
    logic        r_base_in_list;
    logic        r_fault;
    logic [3:0]  r_base_reg;
    logic [4:0]  r_count;
    logic [31:0] r_addr;
    logic [31:0] r_wb_val;

    logic [15:0] w_eff_list;
    logic [15:0] w_list_next;
    logic [4:0]  w_n;
    logic [31:0] w_span;
    logic [31:0] w_start_addr;
    logic [31:0] w_wb_val;
    logic [3:0]  w_cur_reg;
    logic        w_last;
    logic        w_fault;

    // A store can never source the PC, so R15 is dropped from STM/PUSH lists.
    assign w_eff_list = {bus.REGLIST[15] & bus.IS_LOAD, bus.REGLIST[14:0]};

    always_comb begin
        w_n = '0;
        for (int i = 0; i < 16; i++) begin
            w_n = w_n + {4'b0000, w_eff_list[i]};
        end
    end

    assign w_span       = ADDR_STEP * {27'b0, w_n};
    assign w_start_addr = bus.DECR ? (bus.BASE_ADDR - w_span) : bus.BASE_ADDR;
    assign w_wb_val     = bus.DECR ? (bus.BASE_ADDR - w_span) : (bus.BASE_ADDR + w_span);

`ifdef LDM_ALIGN_CHECK_EN
    assign w_fault = (w_start_addr[1:0] != 2'b00);
`else
    assign w_fault = 1'b0;
`endif

    always_comb begin
        w_cur_reg = '0;
        for (int i = 15; i >= 0; i--) begin
            if (r_list[i]) begin
                w_cur_reg = 4'(i);
            end
        end
    end

    assign w_list_next = r_list & ~(16'h0001 << w_cur_reg);
    assign w_last      = (w_list_next == 16'h0000);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_list         <= '0;
            r_is_load      <= 1'b0;
            r_wback        <= 1'b0;
            r_base_in_list <= 1'b0;
            r_fault        <= 1'b0;
            r_base_reg     <= '0;
            r_count        <= '0;
            r_addr         <= '0;
            r_wb_val       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_list         <= w_eff_list;
                        r_is_load      <= bus.IS_LOAD;
                        r_wback        <= bus.WBACK_EN;
                        r_base_in_list <= w_eff_list[bus.BASE_REG];
                        r_fault        <= w_fault;
                        r_base_reg     <= bus.BASE_REG;
                        r_count        <= w_n;
                        r_addr         <= w_start_addr;
                        r_wb_val       <= w_wb_val;
                    end
                end
                S_XFER: begin
                    if (bus.MEM_READY) begin
                        r_list <= w_list_next;
                        r_addr <= r_addr + 32'(ADDR_STEP);
                    end
                end
                S_WB: begin
                    r_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next  = r_state;
        bus.BUSY      = 1'b0;
        bus.DONE      = 1'b0;
        bus.MEM_REQ   = 1'b0;
        bus.MEM_WRITE = 1'b0;
        bus.MEM_ADDR  = '0;
        bus.MEM_WDATA = '0;
        bus.REG_RA    = '0;
        bus.REG_WEN1  = 1'b0;
        bus.REG_WA1   = '0;
        bus.REG_DI1   = '0;
        bus.REG_WEN2  = 1'b0;
        bus.REG_WA2   = '0;
        bus.REG_DI2   = '0;
        bus.PC_WEN    = 1'b0;
        bus.PC_DI     = '0;
        bus.FAULT     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.START) begin
                    w_state_next = (w_n == 5'd0 || w_fault) ? S_WB : S_XFER;
                end
            end
            S_XFER: begin
                bus.BUSY      = 1'b1;
                bus.MEM_REQ   = 1'b1;
                bus.MEM_WRITE = ~r_is_load;
                bus.MEM_ADDR  = r_addr;
                bus.REG_RA    = w_cur_reg;
                if (!r_is_load) begin
                    bus.MEM_WDATA = bus.REG_RDATA;
                end
                if (bus.MEM_READY) begin
                    if (r_is_load) begin
                        // Loads into R15 are branches: redirect the PC, clear the Thumb bit.
                        if (w_cur_reg == 4'd15) begin
                            bus.PC_WEN = 1'b1;
                            bus.PC_DI  = {bus.MEM_RDATA[31:1], 1'b0};
                        end else begin
                            bus.REG_WEN1 = 1'b1;
                            bus.REG_WA1  = w_cur_reg;
                            bus.REG_DI1  = bus.MEM_RDATA;
                        end
                    end
                    if (w_last) begin
                        w_state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                bus.BUSY  = 1'b1;
                bus.DONE  = 1'b1;
                bus.FAULT = r_fault;
                // A loaded base register keeps the loaded value rather than the writeback.
                if (r_wback && r_count != 5'd0 && !(r_is_load && r_base_in_list) && !r_fault) begin
                    bus.REG_WEN2 = 1'b1;
                    bus.REG_WA2  = r_base_reg;
                    bus.REG_DI2  = r_wb_val;
                end
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: scoreboard bench for ldm_stm_sequencer in its default build.
// Expected beats and register writes are queued at stimulus time and popped by a negedge monitor.
module tb_ldm_stm_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ldm_stm_sequencer_if bus();

    ldm_stm_sequencer #(.ADDR_STEP(4)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct packed { logic [31:0] addr; logic wr; logic [31:0] data; } beat_t;
    typedef struct packed { logic [3:0] idx; logic [31:0] data; } wr_t;

    beat_t       beat_q[$];
    wr_t         wen1_q[$];
    logic [31:0] pc_q[$];
    wr_t         wb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem_tab [0:15];

    function automatic logic [31:0] reg_val(input logic [3:0] n);
        return 32'hC0DE_0000 + 32'(n) * 32'h0000_1111;
    endfunction

    assign bus.REG_RDATA = reg_val(bus.REG_RA);
    assign bus.MEM_RDATA = mem_tab[bus.MEM_ADDR[5:2]];

    function automatic int pending();
        return beat_q.size() + wen1_q.size() + pc_q.size() + wb_q.size();
    endfunction

    function automatic logic [179:0] all_outs();
        return {bus.BUSY, bus.DONE, bus.MEM_REQ, bus.MEM_WRITE, bus.MEM_ADDR, bus.MEM_WDATA,
                bus.REG_RA, bus.REG_WEN1, bus.REG_WA1, bus.REG_DI1, bus.REG_WEN2, bus.REG_WA2,
                bus.REG_DI2, bus.PC_WEN, bus.PC_DI, bus.FAULT};
    endfunction

    // Scoreboard monitor: every accepted beat and every register/PC write pops one expectation.
    beat_t       m_b;
    wr_t         m_w;
    logic [31:0] m_pc;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.MEM_REQ === 1'b1 && bus.MEM_READY === 1'b1) begin
                n_tests++;
                if (beat_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat: unexpected beat addr=%h write=%b, required no beat", bus.MEM_ADDR, bus.MEM_WRITE);
                end else begin
                    m_b = beat_q.pop_front();
                    $display("[TB] beat addr=%h write=%b wdata=%h", bus.MEM_ADDR, bus.MEM_WRITE, bus.MEM_WDATA);
                    if (bus.MEM_ADDR !== m_b.addr || bus.MEM_WRITE !== m_b.wr || (m_b.wr && bus.MEM_WDATA !== m_b.data)) begin
                        n_fail++;
                        $display("FAIL beat: got addr=%h wr=%b wdata=%h, required addr=%h wr=%b wdata=%h",
                                 bus.MEM_ADDR, bus.MEM_WRITE, bus.MEM_WDATA, m_b.addr, m_b.wr, m_b.data);
                    end
                end
            end
            if (bus.REG_WEN1 === 1'b1) begin
                n_tests++;
                if (wen1_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wen1: unexpected write R%0d=%h, required none", bus.REG_WA1, bus.REG_DI1);
                end else begin
                    m_w = wen1_q.pop_front();
                    $display("[TB] regwrite R%0d=%h", bus.REG_WA1, bus.REG_DI1);
                    if (bus.REG_WA1 !== m_w.idx || bus.REG_DI1 !== m_w.data) begin
                        n_fail++;
                        $display("FAIL wen1: got R%0d=%h, required R%0d=%h", bus.REG_WA1, bus.REG_DI1, m_w.idx, m_w.data);
                    end
                end
            end
            if (bus.PC_WEN === 1'b1) begin
                n_tests++;
                if (pc_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pc: unexpected PC write %h, required none", bus.PC_DI);
                end else begin
                    m_pc = pc_q.pop_front();
                    $display("[TB] pcwrite %h", bus.PC_DI);
                    if (bus.PC_DI !== m_pc) begin
                        n_fail++;
                        $display("FAIL pc: got %h, required %h", bus.PC_DI, m_pc);
                    end
                end
            end
            if (bus.REG_WEN2 === 1'b1) begin
                n_tests++;
                if (wb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wb: unexpected writeback R%0d=%h, required none", bus.REG_WA2, bus.REG_DI2);
                end else begin
                    m_w = wb_q.pop_front();
                    $display("[TB] writeback R%0d=%h", bus.REG_WA2, bus.REG_DI2);
                    if (bus.REG_WA2 !== m_w.idx || bus.REG_DI2 !== m_w.data) begin
                        n_fail++;
                        $display("FAIL wb: got R%0d=%h, required R%0d=%h", bus.REG_WA2, bus.REG_DI2, m_w.idx, m_w.data);
                    end
                end
            end
            if (bus.DONE === 1'b1) begin
                n_tests++;
                $display("[TB] done");
                if (bus.FAULT !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fault: got %b, required 0", bus.FAULT);
                end
            end
        end
    end

    task automatic start_xfer(input logic ld, input logic dec, input logic wb,
                              input logic [15:0] list, input logic [3:0] breg, input logic [31:0] base);
        @(posedge clk); #1;
        bus.START     = 1'b1;
        bus.IS_LOAD   = ld;
        bus.DECR      = dec;
        bus.WBACK_EN  = wb;
        bus.REGLIST   = list;
        bus.BASE_REG  = breg;
        bus.BASE_ADDR = base;
        @(posedge clk); #1;
        bus.START = 1'b0;
    endtask

    // Returns the cycle (START cycle = 0) in which DONE was seen, or -1 on timeout.
    task automatic wait_done(output int cyc);
        int c;
        c = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.DONE === 1'b1) break;
            @(posedge clk); #1;
            c++;
        end
        cyc = (c > 200) ? -1 : c;
    endtask

    task automatic test_reset();
        bus.START = 1'b0; bus.IS_LOAD = 1'b0; bus.DECR = 1'b0; bus.WBACK_EN = 1'b0;
        bus.REGLIST = '0; bus.BASE_REG = '0; bus.BASE_ADDR = '0; bus.MEM_READY = 1'b1;
        for (int i = 0; i < 16; i++) mem_tab[i] = 32'h1000_0001 + 32'(i) * 32'h0101_0100;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h, required 0", all_outs());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL idle_outs: got %h, required 0", all_outs());
        end
    endtask

    task automatic test_push();
        int cyc;
        beat_q.push_back('{32'h2000_00F4, 1'b1, reg_val(4'd4)});
        beat_q.push_back('{32'h2000_00F8, 1'b1, reg_val(4'd5)});
        beat_q.push_back('{32'h2000_00FC, 1'b1, reg_val(4'd14)});
        wb_q.push_back('{4'd13, 32'h2000_00F4});
        start_xfer(1'b0, 1'b1, 1'b1, 16'h4030, 4'd13, 32'h2000_0100);
        n_tests++;
        if (bus.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL push_busy: got %b, required 1", bus.BUSY);
        end
        wait_done(cyc); #1;
        n_tests++;
        if (cyc !== 4) begin n_fail++; $display("FAIL push_latency: got %0d, required 4", cyc); end
        n_tests++;
        if (pending() != 0) begin n_fail++; $display("FAIL push_drain: pending=%0d, required 0", pending()); end
    endtask

    task automatic test_pop();
        int cyc;
        mem_tab[14] = 32'h0000_0011;
        mem_tab[15] = 32'h0000_0203;
        beat_q.push_back('{32'h2000_00F8, 1'b0, 32'h0});
        beat_q.push_back('{32'h2000_00FC, 1'b0, 32'h0});
        wen1_q.push_back('{4'd0, 32'h0000_0011});
        pc_q.push_back(32'h0000_0202);
        wb_q.push_back('{4'd13, 32'h2000_0100});
        start_xfer(1'b1, 1'b0, 1'b1, 16'h8001, 4'd13, 32'h2000_00F8);
        wait_done(cyc); #1;
        n_tests++;
        if (cyc !== 3) begin n_fail++; $display("FAIL pop_latency: got %0d, required 3", cyc); end
        n_tests++;
        if (pending() != 0) begin n_fail++; $display("FAIL pop_drain: pending=%0d, required 0", pending()); end
    endtask

    task automatic test_ldm_base_in_list();
        int cyc;
        beat_q.push_back('{32'h2000_0040, 1'b0, 32'h0});
        beat_q.push_back('{32'h2000_0044, 1'b0, 32'h0});
        wen1_q.push_back('{4'd1, mem_tab[0]});
        wen1_q.push_back('{4'd2, mem_tab[1]});
        start_xfer(1'b1, 1'b0, 1'b1, 16'h0006, 4'd1, 32'h2000_0040);
        wait_done(cyc); #1;
        n_tests++;
        if (cyc !== 3) begin n_fail++; $display("FAIL basein_latency: got %0d, required 3", cyc); end
        n_tests++;
        if (pending() != 0) begin n_fail++; $display("FAIL basein_drain: pending=%0d, required 0", pending()); end
    endtask

    task automatic test_stall();
        int done_c;
        done_c = -1;
        beat_q.push_back('{32'h0000_4000, 1'b1, reg_val(4'd1)});
        beat_q.push_back('{32'h0000_4004, 1'b1, reg_val(4'd2)});
        beat_q.push_back('{32'h0000_4008, 1'b1, reg_val(4'd3)});
        start_xfer(1'b0, 1'b0, 1'b0, 16'h000E, 4'd0, 32'h0000_4000);
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            bus.MEM_READY = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                n_tests++;
                if (bus.MEM_REQ !== 1'b1 || bus.MEM_ADDR !== 32'h0000_4004 || bus.MEM_WDATA !== reg_val(4'd2)) begin
                    n_fail++;
                    $display("FAIL stall_hold c=%0d: got req=%b addr=%h wdata=%h, required req=1 addr=00004004 wdata=%h",
                             c, bus.MEM_REQ, bus.MEM_ADDR, bus.MEM_WDATA, reg_val(4'd2));
                end
            end
            if (bus.DONE === 1'b1) begin
                done_c = c;
                break;
            end
        end
        bus.MEM_READY = 1'b1;
        #1;
        n_tests++;
        if (done_c !== 7) begin n_fail++; $display("FAIL stall_latency: got %0d, required 7", done_c); end
        n_tests++;
        if (pending() != 0) begin n_fail++; $display("FAIL stall_drain: pending=%0d, required 0", pending()); end
    endtask

    task automatic test_empty();
        int cyc;
        start_xfer(1'b0, 1'b0, 1'b1, 16'h0000, 4'd13, 32'h2000_0000);
        n_tests++;
        if (bus.BUSY !== 1'b1 || bus.MEM_REQ !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_busy: got busy=%b req=%b, required busy=1 req=0", bus.BUSY, bus.MEM_REQ);
        end
        wait_done(cyc); #1;
        n_tests++;
        if (cyc !== 1) begin n_fail++; $display("FAIL empty_latency: got %0d, required 1", cyc); end
        // STM naming only R15 has an empty effective list.
        start_xfer(1'b0, 1'b0, 1'b1, 16'h8000, 4'd13, 32'h2000_0000);
        wait_done(cyc); #1;
        n_tests++;
        if (cyc !== 1) begin n_fail++; $display("FAIL stm_r15_latency: got %0d, required 1", cyc); end
        n_tests++;
        if (pending() != 0) begin n_fail++; $display("FAIL empty_drain: pending=%0d, required 0", pending()); end
    endtask

    task automatic test_full_list();
        int cyc;
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            a = 32'h0000_0020 - 32'd64 + 32'(4 * i);
            d = mem_tab[a[5:2]];
            beat_q.push_back('{a, 1'b0, 32'h0});
            if (i < 15) wen1_q.push_back('{4'(i), d});
            else        pc_q.push_back({d[31:1], 1'b0});
        end
        start_xfer(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'd13, 32'h0000_0020);
        wait_done(cyc); #1;
        n_tests++;
        if (cyc !== 17) begin n_fail++; $display("FAIL full_latency: got %0d, required 17", cyc); end
        n_tests++;
        if (pending() != 0) begin n_fail++; $display("FAIL full_drain: pending=%0d, required 0", pending()); end
    endtask

    task automatic test_back_to_back();
        int dones;
        int done_c;
        dones  = 0;
        done_c = -1;
        beat_q.push_back('{32'h0000_1000, 1'b1, reg_val(4'd0)});
        wb_q.push_back('{4'd2, 32'h0000_1004});
        @(posedge clk); #1;
        bus.START = 1'b1; bus.IS_LOAD = 1'b0; bus.DECR = 1'b0; bus.WBACK_EN = 1'b1;
        bus.REGLIST = 16'h8001; bus.BASE_REG = 4'd2; bus.BASE_ADDR = 32'h0000_1000;
        // START stays high through the DONE cycle and must not launch a second transfer.
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (done_c > 0 && c == done_c + 1) bus.START = 1'b0;
            @(negedge clk);
            if (bus.DONE === 1'b1) begin
                dones++;
                done_c = c;
            end
        end
        bus.START = 1'b0;
        #1;
        n_tests++;
        if (dones !== 1 || done_c !== 2) begin
            n_fail++;
            $display("FAIL b2b_done: got count=%0d cycle=%0d, required count=1 cycle=2", dones, done_c);
        end
        n_tests++;
        if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b, required 0", bus.BUSY); end
        n_tests++;
        if (pending() != 0) begin n_fail++; $display("FAIL b2b_drain: pending=%0d, required 0", pending()); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        beat_q.push_back('{32'h0000_3000, 1'b1, reg_val(4'd0)});
        beat_q.push_back('{32'h0000_3004, 1'b1, reg_val(4'd1)});
        start_xfer(1'b0, 1'b0, 1'b1, 16'h000F, 4'd5, 32'h0000_3000);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL midreset_outs: got %h, required 0", all_outs());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL midreset_hold: got %h, required 0", all_outs());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_tests++;
        if (pending() != 0) begin n_fail++; $display("FAIL midreset_drain: pending=%0d, required 0", pending()); end
        beat_q.push_back('{32'h0000_300C, 1'b1, reg_val(4'd7)});
        wb_q.push_back('{4'd13, 32'h0000_300C});
        start_xfer(1'b0, 1'b1, 1'b1, 16'h0080, 4'd13, 32'h0000_3010);
        wait_done(cyc); #1;
        n_tests++;
        if (cyc !== 2) begin n_fail++; $display("FAIL postreset_latency: got %0d, required 2", cyc); end
        n_tests++;
        if (pending() != 0) begin n_fail++; $display("FAIL postreset_drain: pending=%0d, required 0", pending()); end
    endtask

    initial begin
        test_reset();
        test_push();
        test_pop();
        test_ldm_base_in_list();
        test_stall();
        test_empty();
        test_full_list();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
Multi-register transfer sequencer for the Cortex-M0 core. It executes LDM/STM/PUSH/POP instructions one register per memory beat. For stores, it reads registers through one regfile read port. For loads, it writes loaded data through regfile write port 1 and updates the base register through write port 2. It sits between decode/execute and the register file and data-bus interface, and stalls the pipeline through BUSY.

Parameters:
ADDR_STEP, 4, byte increment per beat (word transfers)

Ports:
CLK  input  1  clock; all state changes on rising edge
nRST  input  1  asynchronous active-low reset
START  input  1  start request; sampled only in IDLE
IS_LOAD  input  1  1 = LDM/POP, 0 = STM/PUSH
DECR  input  1  1 = decrement-before (PUSH), 0 = increment-after
WBACK_EN  input  1  write updated base to BASE_REG
REGLIST  input  16  register list; bit n = Rn
BASE_REG  input  4  base register index
BASE_ADDR  input  32  base register value at START
BUSY  output  1  high while a transfer is in progress
DONE  output  1  one-cycle completion pulse
MEM_REQ  output  1  bus request
MEM_WRITE  output  1  1 = write beat
MEM_ADDR  output  32  beat address
MEM_WDATA  output  32  store data
MEM_READY  input  1  beat accepted/completed this cycle
MEM_RDATA  input  32  load data, valid when MEM_READY
REG_RA  output  4  regfile read address for store data
REG_RDATA  input  32  regfile combinational read data
REG_WEN1 / REG_WA1 / REG_DI1  output  1/4/32  load write port
REG_WEN2 / REG_WA2 / REG_DI2  output  1/4/32  base writeback port
PC_WEN  output  1  pulse: load into PC (R15)
PC_DI  output  32  new PC value
FAULT  output  1  alignment fault pulse (optional feature only)

Behaviour:
- Reset: all outputs are 0, state is IDLE, and internal list/address/count registers are 0. An asynchronous reset mid-transfer aborts immediately; no further beats or writes occur.
- START handling: a START sampled in IDLE latches the effective list, IS_LOAD, DECR, WBACK_EN, BASE_REG, and BASE_ADDR. START is ignored while BUSY.
- Effective list: REGLIST, with bit 15 forced to 0 when IS_LOAD=0.
- Beat count: N = popcount(effective list), range 0..16.
- Start address: DECR=1 gives BASE_ADDR - ADDR_STEP*N; DECR=0 gives BASE_ADDR.
- Address order: the lowest-numbered register always uses the lowest address, ascending by ADDR_STEP. All arithmetic is modulo 2^32.
- Writeback value:
  - DECR=1: BASE_ADDR - ADDR_STEP*N.
  - DECR=0: BASE_ADDR + ADDR_STEP*N.
- States: IDLE, XFER, WB.
  - IDLE -> XFER on START when N>0. MEM_REQ rises the cycle after START.
  - IDLE -> WB on START when N=0: no bus beats, no writeback, DONE pulses.
- XFER beats:
  - MEM_REQ=1, MEM_WRITE=~IS_LOAD, MEM_ADDR = current address, REG_RA = current register.
  - MEM_WDATA = REG_RDATA, combinational.
  - MEM_ADDR, MEM_WRITE, and register selection are held stable until a cycle with MEM_READY=1.
  - On MEM_READY: clear the current list bit, advance the address, and select the next-lowest set bit. After the last beat, go to WB.
- Load write, in the MEM_READY cycle:
  - Register < 15: REG_WEN1=1, REG_WA1 = register, REG_DI1 = MEM_RDATA.
  - R15: PC_WEN=1, PC_DI = {MEM_RDATA[31:1],1'b0}, REG_WEN1=0.
- WB state (exactly one cycle): DONE=1, MEM_REQ=0.
  - REG_WEN2=1, REG_WA2=BASE_REG, REG_DI2 = writeback value, if WBACK_EN=1, N>0, and not (IS_LOAD=1 and BASE_REG in list).
  - Then return to IDLE.
- BUSY: high from the cycle after START through the WB cycle inclusive.
- Back-to-back: minimum transfer time for N beats with MEM_READY always high is N+1 cycles from START to DONE. A START sampled in the DONE cycle is ignored, because BUSY is still 1.

Optional Feature:
LDM_ALIGN_CHECK_EN
- Defined: at START, the computed start address is checked. If start address[1:0] != 0:
  - no beats and no writeback occur;
  - the FSM goes to WB with FAULT=1 and DONE=1 for one cycle.
- Undefined: no check is made; the address is used as-is and FAULT is tied 0.

Test Plan:
1. PUSH {R4,R5,LR}: DECR=1, STM, BASE_ADDR=0x2000_0100, WBACK_EN=1, BASE_REG=13, MEM_READY=1.
   -> Writes at 0x2000_00F4/F8/FC with R4/R5/R14 data.
   -> REG_WEN2 writes R13=0x2000_00F4; DONE 4 cycles after START.
2. POP {R0,PC}: LDM, DECR=0, base 0x2000_00F8, RDATA 0x11 then 0x0000_0203.
   -> REG_WEN1 writes R0=0x11; PC_WEN with PC_DI=0x0000_0202; R13=0x2000_0100.
3. LDM R1!,{R1,R2}: base in list.
   -> R1 and R2 loaded; REG_WEN2 never asserted.
4. MEM_READY low for 3 cycles on beat 2 of a 3-register STM.
   -> MEM_ADDR and MEM_WDATA are stable throughout the stall; total time is 7 cycles.
5. Empty REGLIST with WBACK_EN=1.
   -> No MEM_REQ, no writes; DONE in the cycle after START.
6. nRST asserted mid-transfer (beat 2 of 4).
   -> All outputs are 0 immediately; a new START after reset runs normally from IDLE.
